// File: rtl/ram_responder.sv
// Single-port data RAM serving the CPU decoder: 1-cycle registered reads,
// power-up clear sweep, side-band debug load port and saturating access counters.
module ram_responder #(
    parameter int DATA_W       = 4,
    parameter int ADDR_W       = 4,
    parameter bit CLR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csn,
    input  logic              rwn,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_data_in,
    output logic [DATA_W-1:0] ram_data_out,
    output logic              rd_valid,
    output logic              busy,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              dbg_collision,
    output logic [7:0]        rd_cnt,
    output logic [7:0]        wr_cnt
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
    localparam logic [7:0]        CNT_MAX  = 8'hFF;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] ptr_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              cpu_rd_s;
    logic              cpu_wr_s;
    logic              dbg_wr_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;

    // Select the single array write source for this cycle: sweep, CPU or debug port.
    always_comb begin
        cpu_rd_s    = 1'b0;
        cpu_wr_s    = 1'b0;
        dbg_wr_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = {ADDR_W{1'b0}};
        mem_wdata_s = {DATA_W{1'b0}};
        case (state_r)
            CLEAR: begin
                if (CLR_ON_RESET) begin
                    mem_we_s   = 1'b1;
                    mem_addr_s = ptr_r;
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            SERVE: begin
                cpu_rd_s = ~csn & rwn;
                cpu_wr_s = ~csn & ~rwn;
                dbg_wr_s = csn & dbg_we;
                if (cpu_wr_s) begin
                    mem_we_s    = 1'b1;
                    mem_addr_s  = ram_addr;
                    mem_wdata_s = ram_data_in;
                end else if (dbg_wr_s) begin
                    mem_we_s    = 1'b1;
                    mem_addr_s  = dbg_addr;
                    mem_wdata_s = dbg_data;
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            default: begin
                mem_we_s = 1'b0;
            end
        endcase
    end

    // Storage array; contents survive reset, and a write in a reset cycle is suppressed.
    always_ff @(posedge clk) begin
        if (mem_we_s && !rst) begin
            mem_r[mem_addr_s] <= mem_wdata_s;
        end
    end

    // Control FSM with registered read data, status flags and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= CLEAR;
            ptr_r         <= {ADDR_W{1'b0}};
            ram_data_out  <= {DATA_W{1'b0}};
            rd_valid      <= 1'b0;
            busy          <= 1'b1;
            dbg_collision <= 1'b0;
            rd_cnt        <= 8'd0;
            wr_cnt        <= 8'd0;
        end else begin
            case (state_r)
                CLEAR: begin
                    rd_valid <= 1'b0;
                    if (dbg_we) begin
                        dbg_collision <= 1'b1;
                    end
                    if (!CLR_ON_RESET || ptr_r == PTR_LAST) begin
                        state_r <= SERVE;
                        busy    <= 1'b0;
                        ptr_r   <= {ADDR_W{1'b0}};
                    end else begin
                        ptr_r <= ptr_r + ADDR_W'(1);
                    end
                end
                SERVE: begin
                    rd_valid <= cpu_rd_s;
                    if (cpu_rd_s) begin
                        ram_data_out <= mem_r[ram_addr];
                        if (rd_cnt != CNT_MAX) begin
                            rd_cnt <= rd_cnt + 8'd1;
                        end
                    end
                    if (cpu_wr_s && wr_cnt != CNT_MAX) begin
                        wr_cnt <= wr_cnt + 8'd1;
                    end
                    // A CPU request always wins; a simultaneous debug write is lost.
                    if (!csn && dbg_we) begin
                        dbg_collision <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= CLEAR;
                    ptr_r    <= {ADDR_W{1'b0}};
                    busy     <= 1'b1;
                    rd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: one instance with the clear sweep, one without.
module tb_ram_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, csn, rwn, dbg_we;
    logic [3:0] ram_addr, ram_data_in, dbg_addr, dbg_data;
    logic [3:0] ram_data_out;
    logic       rd_valid, busy, dbg_collision;
    logic [7:0] rd_cnt, wr_cnt;

    logic       rst0, csn0, rwn0, dbg_we0;
    logic [3:0] ram_addr0, ram_data_in0, dbg_addr0, dbg_data0;
    logic [3:0] ram_data_out0;
    logic       rd_valid0, busy0, dbg_collision0;
    logic [7:0] rd_cnt0, wr_cnt0;

    int         errors = 0;
    int         checks = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp0_q[$];
    logic [3:0] exp_mon, exp_mon0;
    int         n;

    ram_responder #(.DATA_W(4), .ADDR_W(4), .CLR_ON_RESET(1'b1)) u_dut (
        .clk(clk), .rst(rst), .csn(csn), .rwn(rwn), .ram_addr(ram_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .rd_valid(rd_valid),
        .busy(busy), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .dbg_collision(dbg_collision), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    ram_responder #(.DATA_W(4), .ADDR_W(4), .CLR_ON_RESET(1'b0)) u_dut0 (
        .clk(clk), .rst(rst0), .csn(csn0), .rwn(rwn0), .ram_addr(ram_addr0),
        .ram_data_in(ram_data_in0), .ram_data_out(ram_data_out0), .rd_valid(rd_valid0),
        .busy(busy0), .dbg_we(dbg_we0), .dbg_addr(dbg_addr0), .dbg_data(dbg_data0),
        .dbg_collision(dbg_collision0), .rd_cnt(rd_cnt0), .wr_cnt(wr_cnt0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the sweeping instance: every rd_valid pulse pops one expectation.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rd_valid: got pulse with data %0h, expected none", ram_data_out);
            end else begin
                exp_mon = exp_q.pop_front();
                check("rd_data", {28'd0, ram_data_out}, {28'd0, exp_mon});
            end
        end
    end

    // Monitor for the non-sweeping instance.
    always @(negedge clk) begin
        if (rd_valid0 === 1'b1) begin
            if (exp0_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rd_valid0: got pulse with data %0h, expected none", ram_data_out0);
            end else begin
                exp_mon0 = exp0_q.pop_front();
                check("rd_data0", {28'd0, ram_data_out0}, {28'd0, exp_mon0});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        csn = 1'b1; rwn = 1'b1; dbg_we = 1'b0;
        csn0 = 1'b1; rwn0 = 1'b1; dbg_we0 = 1'b0;
    endtask

    task automatic rd(input bit sel, input logic [3:0] a, input logic [3:0] e);
        if (sel) begin
            csn0 = 1'b0; rwn0 = 1'b1; ram_addr0 = a; exp0_q.push_back(e);
        end else begin
            csn = 1'b0; rwn = 1'b1; ram_addr = a; exp_q.push_back(e);
        end
        step();
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] d);
        csn = 1'b0; rwn = 1'b0; ram_addr = a; ram_data_in = d;
        step();
    endtask

    task automatic dbg(input bit sel, input logic [3:0] a, input logic [3:0] d);
        if (sel) begin
            csn0 = 1'b1; dbg_we0 = 1'b1; dbg_addr0 = a; dbg_data0 = d;
        end else begin
            csn = 1'b1; dbg_we = 1'b1; dbg_addr = a; dbg_data = d;
        end
        step();
    endtask

    // Counts negedges with busy high, bounded so a stuck busy still ends.
    task automatic count_busy(input bit sel, output int cnt);
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if ((sel ? busy0 : busy) === 1'b1) cnt++;
            else break;
        end
    endtask

    initial begin
        rst = 1'b1; rst0 = 1'b1;
        ram_addr = 4'd0; ram_data_in = 4'd0; dbg_addr = 4'd0; dbg_data = 4'd0;
        ram_addr0 = 4'd0; ram_data_in0 = 4'd0; dbg_addr0 = 4'd0; dbg_data0 = 4'd0;
        idle();
        repeat (3) step();

        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_data_out", {28'd0, ram_data_out}, 32'd0);
        check("rst_collision", {31'd0, dbg_collision}, 32'd0);
        check("rst_rd_cnt", {24'd0, rd_cnt}, 32'd0);
        check("rst_wr_cnt", {24'd0, wr_cnt}, 32'd0);

        @(posedge clk); #1;
        rst = 1'b0;
        count_busy(1'b0, n);
        check("sweep_busy_len", n, 32'd16);
        idle();

        for (int a = 0; a < 16; a++) rd(1'b0, 4'(a), 4'h0);
        idle(); step(); step();
        check("rd_cnt_16", {24'd0, rd_cnt}, 32'd16);

        wr(4'd3, 4'hA);
        rd(1'b0, 4'd3, 4'hA);
        idle(); step(); step();
        check("wr_cnt_1", {24'd0, wr_cnt}, 32'd1);
        check("rd_cnt_17", {24'd0, rd_cnt}, 32'd17);

        dbg(1'b0, 4'd7, 4'h5);
        rd(1'b0, 4'd7, 4'h5);
        dbg_we = 1'b1; dbg_addr = 4'd7; dbg_data = 4'hC;
        rd(1'b0, 4'd7, 4'h5);
        idle();
        rd(1'b0, 4'd7, 4'h5);
        idle(); step(); step();
        check("collision_set", {31'd0, dbg_collision}, 32'd1);
        check("wr_cnt_dbg_untouched", {24'd0, wr_cnt}, 32'd1);
        check("rd_cnt_20", {24'd0, rd_cnt}, 32'd20);

        for (int i = 0; i < 300; i++) rd(1'b0, 4'd0, 4'h0);
        idle(); step(); step();
        check("rd_cnt_sat", {24'd0, rd_cnt}, 32'd255);
        for (int i = 0; i < 300; i++) wr(4'd5, 4'(i));
        idle(); step();
        check("wr_cnt_sat", {24'd0, wr_cnt}, 32'd255);
        rd(1'b0, 4'd5, 4'hB);
        idle(); step(); step();
        check("collision_sticky", {31'd0, dbg_collision}, 32'd1);
        check("rd_cnt_stays_sat", {24'd0, rd_cnt}, 32'd255);

        // Fill with 0xF, then abort a sweep halfway and let it restart.
        for (int a = 0; a < 16; a++) dbg(1'b0, 4'(a), 4'hF);
        idle(); step();
        rst = 1'b1; step(); step();
        @(negedge clk);
        check("rst2_collision", {31'd0, dbg_collision}, 32'd0);
        check("rst2_rd_cnt", {24'd0, rd_cnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) step();
        rst = 1'b1; step();
        rst = 1'b0;
        csn = 1'b0; rwn = 1'b0; ram_addr = 4'd2; ram_data_in = 4'h9;
        dbg_we = 1'b1; dbg_addr = 4'd2; dbg_data = 4'h6;
        count_busy(1'b0, n);
        idle();
        check("resweep_busy_len", n, 32'd16);
        check("clear_collision", {31'd0, dbg_collision}, 32'd1);
        check("clear_wr_cnt", {24'd0, wr_cnt}, 32'd0);
        for (int a = 0; a < 16; a++) rd(1'b0, 4'(a), 4'h0);
        idle(); step(); step();
        check("resweep_rd_cnt", {24'd0, rd_cnt}, 32'd16);
        check("resweep_wr_cnt", {24'd0, wr_cnt}, 32'd0);

        // Instance without the sweep: busy lasts one cycle and contents persist over reset.
        @(posedge clk); #1;
        rst0 = 1'b0;
        count_busy(1'b1, n);
        idle();
        check("noclr_busy_len", n, 32'd1);
        dbg(1'b1, 4'd4, 4'hF);
        dbg(1'b1, 4'd9, 4'hF);
        rd(1'b1, 4'd4, 4'hF);
        idle(); step(); step();
        rst0 = 1'b1; step(); step();
        @(negedge clk);
        check("noclr_rst_busy", {31'd0, busy0}, 32'd1);
        check("noclr_rst_data", {28'd0, ram_data_out0}, 32'd0);
        @(posedge clk); #1;
        rst0 = 1'b0;
        count_busy(1'b1, n);
        idle();
        check("noclr_busy_len2", n, 32'd1);
        rd(1'b1, 4'd4, 4'hF);
        rd(1'b1, 4'd9, 4'hF);
        idle(); step(); step();
        check("noclr_rd_cnt", {24'd0, rd_cnt0}, 32'd2);

        check("queues_drained", exp_q.size() + exp0_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
# ram_responder

Single-port 16x4 data RAM that answers the CPU decoder FSM's memory requests (chip select `csn`, read/write `rwn`, address, write data) and returns read data one cycle later. It sits between the decoder FSM and the operand storage. It also provides:
- a power-up clear sweep,
- a side-band debug load port used by benches and boot logic,
- saturating access counters for bring-up.

## Interface
Parameters
- DATA_W, 4, data word width (matches the CPU datapath)
- ADDR_W, 4, address width; depth = 2**ADDR_W
- CLR_ON_RESET, 1, 1 = sweep all words to 0 after reset release; 0 = skip the sweep

Ports
- clk  in  1  single system clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- csn  in  1  chip select, active low (0 = request)
- rwn  in  1  1 = read, 0 = write; sampled only when csn=0
- ram_addr  in  ADDR_W  request address
- ram_data_in  in  DATA_W  write data
- ram_data_out  out  DATA_W  registered read data
- rd_valid  out  1  one-cycle pulse marking new ram_data_out
- busy  out  1  high while reset is asserted or the clear sweep is running
- dbg_we  in  1  debug write strobe
- dbg_addr  in  ADDR_W  debug write address
- dbg_data  in  DATA_W  debug write data
- dbg_collision  out  1  sticky flag: a debug write was dropped
- rd_cnt  out  8  count of accepted reads, saturating at 255
- wr_cnt  out  8  count of accepted CPU writes, saturating at 255

## Operation
- States: CLEAR, SERVE.
- While rst=1, asynchronously force:
  - state=CLEAR, sweep pointer=0;
  - ram_data_out=0, rd_valid=0, busy=1;
  - dbg_collision=0, rd_cnt=0, wr_cnt=0.
  - The array contents are not asynchronously reset.
- CLEAR (CLR_ON_RESET=1):
  - Each cycle, write 0 to mem[ptr] and increment ptr.
  - After writing address 2**ADDR_W-1, go to SERVE and drop busy on the same edge.
  - CPU requests and debug writes are ignored (no array write, no counter change, rd_valid=0).
  - Each ignored debug write sets dbg_collision.
- CLR_ON_RESET=0: the first edge after rst release moves CLEAR to SERVE; busy falls on that edge.
- SERVE, one action per cycle, in this priority:
  - csn=0, rwn=1: ram_data_out <= mem[ram_addr]; rd_valid=1 for the next cycle; rd_cnt increments.
  - csn=0, rwn=0: mem[ram_addr] <= ram_data_in; ram_data_out holds; wr_cnt increments.
  - csn=1, dbg_we=1: mem[dbg_addr] <= dbg_data. Counters are unchanged.
  - csn=1, dbg_we=0: idle; ram_data_out holds its last value.
  - csn=0 and dbg_we=1 together: the CPU access is performed, the debug write is dropped, and dbg_collision is set.
- dbg_collision stays set until rst.
- Counters stick at 255; they never wrap.
- Writes ignore rwn/csn X-free assumptions: when csn=1, rwn and ram_addr are don't-care.

## Timing
- Read latency is 1 cycle. For a request sampled at edge N, ram_data_out is valid and rd_valid=1 after edge N and held through edge N+1. This matches a decoder that issues the read in FETCH and consumes it in EXEC.
- A write at edge N is visible to a read sampled at edge N+1 or later. No bypass is needed: a single port cannot read and write in the same cycle.
- rd_valid is high for exactly one cycle per accepted read. Back-to-back reads give consecutive rd_valid pulses.
- Clear sweep duration is exactly 2**ADDR_W cycles: busy is high for 16 cycles after rst release with the defaults.
- Reset mid-operation: rst asserted during any read, write or sweep aborts it immediately.
  - The aborted write may or may not land.
  - On release, the sweep restarts at address 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset then release: busy=1 for 16 cycles then 0, ram_data_out=0, counters=0, dbg_collision=0. Read all 16 addresses: every word is 0 and rd_cnt=16.
- Write 0xA to addr 3 (csn=0, rwn=0), then read addr 3 on the next cycle: ram_data_out=0xA with rd_valid high exactly one cycle after the read edge, wr_cnt=1.
- Debug load: dbg_we writes 0x5 to addr 7 with csn=1, then a CPU read of addr 7 returns 0x5. Then dbg_we=1 with csn=0 (read addr 7): 0x5 is returned, the debug write is dropped, and dbg_collision=1 and stays 1.
- Saturation: 300 reads yield rd_cnt=255. 300 writes yield wr_cnt=255.
- Reset mid-sweep: assert rst at sweep cycle 8 after writing 0xF everywhere via debug (with CLR_ON_RESET=0 first). On release with CLR_ON_RESET=1, all 16 words read back 0 and busy lasts exactly 16 cycles.
- CPU request during CLEAR: write 0x9 to addr 2 while busy=1. After busy falls, addr 2 reads 0 and wr_cnt=0.
